// File: rtl/pwm_drive_sequencer.sv
// pwm_drive_sequencer
// Turns a signed speed command into a slew-limited duty magnitude and a direction
// for one PWM/H-bridge channel. Duty and direction only move on PWM period
// boundaries. A direction reversal first ramps the duty down to zero, then holds
// the bridge off for a fixed number of whole PWM periods.
//
// Command handshake: cmd_vld is a one-cycle strobe with no back-pressure. Every
// cycle in which cmd_vld is high latches cmd as the new target, and the newest
// strobe wins. A strobe in the period-end cycle is seen from the following
// period end, because that boundary still uses the previously latched target.
module pwm_drive_sequencer #(
    parameter int unsigned STEP     = 16,
    parameter int unsigned DEAD_PER = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] cmd,
    input  logic        cmd_vld,
    output logic [10:0] duty,
    output logic        dir,
    output logic        drive_en,
    output logic        period_end
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        DEAD = 2'd3
    } state_t;

    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [3:0]  DEAD_W = 4'(DEAD_PER);

    state_t      state;
    logic [10:0] per_cnt;
    logic        pend;
    logic [10:0] tgt_mag;
    logic        tgt_dir;
    logic [3:0]  dead_cnt;

    // Command magnitude, with -2048 saturated to 2047
    logic [11:0] cmd_neg;
    logic [10:0] cmd_mag;

    // 12-bit unsigned intermediates for the per-period duty step
    logic [11:0] duty_x;
    logic [11:0] tgt_x;
    logic [11:0] up_gap;
    logic [11:0] dn_gap;
    logic [11:0] up_step;
    logic [11:0] dn_step;
    logic [11:0] seek_duty;
    logic [11:0] decay_duty;
    logic [11:0] rise_duty;
    logic        seek_hit;
    logic        rise_hit;
    logic        decay_zero;

    // Free-running period counter, kept in lock-step with the PWM generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= 11'd0;
        end else begin
            per_cnt <= per_cnt + 11'd1;
        end
    end

    assign pend       = (per_cnt == 11'h7FF);
    assign period_end = pend;

    // Absolute value of the signed command, saturating the single overflow case
    always_comb begin
        cmd_neg = ~cmd + 12'd1;
        cmd_mag = cmd[10:0];
        if (cmd[11]) begin
            if (cmd_neg[11]) begin
                cmd_mag = 11'h7FF;
            end else begin
                cmd_mag = cmd_neg[10:0];
            end
        end
    end

    // Target register: captured on every strobe, independent of enable and state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_mag <= 11'd0;
            tgt_dir <= 1'b1;
        end else if (cmd_vld) begin
            tgt_mag <= cmd_mag;
            tgt_dir <= ~cmd[11];
        end
    end

    // Candidate duty values for the three ways a period boundary can move duty
    always_comb begin
        duty_x  = {1'b0, duty};
        tgt_x   = {1'b0, tgt_mag};
        up_gap  = tgt_x - duty_x;
        dn_gap  = duty_x - tgt_x;
        up_step = (up_gap < STEP_W) ? up_gap : STEP_W;
        dn_step = (dn_gap < STEP_W) ? dn_gap : STEP_W;

        // Move toward the target without overshooting it
        seek_duty = duty_x;
        if (duty_x < tgt_x) begin
            seek_duty = duty_x + up_step;
        end else if (duty_x > tgt_x) begin
            seek_duty = duty_x - dn_step;
        end

        // Move toward zero without going below it
        decay_duty = duty_x - ((duty_x < STEP_W) ? duty_x : STEP_W);

        // First step out of IDLE always starts from zero
        rise_duty = (tgt_x < STEP_W) ? tgt_x : STEP_W;
    end

    assign seek_hit   = (seek_duty == tgt_x);
    assign rise_hit   = (rise_duty == tgt_x);
    assign decay_zero = (decay_duty == 12'd0);

    // Sequencer FSM: enable drop acts at once, everything else waits for period end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= 11'd0;
            dir      <= 1'b1;
            drive_en <= 1'b0;
            dead_cnt <= 4'd0;
        end else if (!en) begin
            state    <= IDLE;
            duty     <= 11'd0;
            drive_en <= 1'b0;
            dead_cnt <= 4'd0;
        end else if (pend) begin
            unique case (state)
                IDLE: begin
                    dir      <= tgt_dir;
                    drive_en <= 1'b1;
                    duty     <= rise_duty[10:0];
                    state    <= rise_hit ? HOLD : RAMP;
                end
                RAMP, HOLD: begin
                    if (tgt_dir == dir) begin
                        duty  <= seek_duty[10:0];
                        state <= seek_hit ? HOLD : RAMP;
                    end else begin
                        // Reversal: bleed off duty first, bridge stays on until zero
                        duty <= decay_duty[10:0];
                        if (decay_zero) begin
                            state    <= DEAD;
                            drive_en <= 1'b0;
                            dead_cnt <= DEAD_W;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                DEAD: begin
                    // Whole periods with the bridge off; target updates cannot cut this short
                    duty     <= 11'd0;
                    drive_en <= 1'b0;
                    if (dead_cnt == 4'd1) begin
                        dir      <= tgt_dir;
                        drive_en <= 1'b1;
                        state    <= RAMP;
                    end else begin
                        dead_cnt <= dead_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_drive_sequencer.sv
// Bench for pwm_drive_sequencer. Channel 0 uses the default step/dead-time and runs
// the directed scenarios; channel 1 uses a large step and a one-period dead-time,
// covers the top-of-range cases, then runs on random commands and enable drops.
// Both are compared against a period-level behavioural model.
module tb_pwm_drive_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] cmd;
    logic        cmd_vld;
    logic [10:0] duty;
    logic        dir;
    logic        drive_en;
    logic        period_end;

    logic        en2;
    logic [11:0] cmd2;
    logic        cmd_vld2;
    logic [10:0] duty2;
    logic        dir2;
    logic        drive_en2;
    logic        period_end2;

    int nvec  = 0;
    int nfail = 0;
    bit rnd_on = 0;

    // Behavioural model state, one slot per channel
    int m_cnt;
    int m_duty[2];
    bit m_dir[2];
    bit m_run[2];
    int m_dead[2];
    int t_mag[2];
    bit t_dir[2];
    int step_of[2];
    int dead_of[2];

    pwm_drive_sequencer u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cmd        (cmd),
        .cmd_vld    (cmd_vld),
        .duty       (duty),
        .dir        (dir),
        .drive_en   (drive_en),
        .period_end (period_end)
    );

    pwm_drive_sequencer #(.STEP(700), .DEAD_PER(1)) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en2),
        .cmd        (cmd2),
        .cmd_vld    (cmd_vld2),
        .duty       (duty2),
        .dir        (dir2),
        .drive_en   (drive_en2),
        .period_end (period_end2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        step_of[0] = 16;
        step_of[1] = 700;
        dead_of[0] = 2;
        dead_of[1] = 1;
        m_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            m_duty[c] = 0;
            m_dir[c]  = 1'b1;
            m_run[c]  = 1'b0;
            m_dead[c] = 0;
            t_mag[c]  = 0;
            t_dir[c]  = 1'b1;
        end
    endtask

    // One PWM period boundary for channel c, in terms of the documented rules
    task automatic model_period(input int c);
        int delta;
        if (!m_run[c]) begin
            m_dir[c]  = t_dir[c];
            m_run[c]  = 1'b1;
            m_duty[c] = (t_mag[c] < step_of[c]) ? t_mag[c] : step_of[c];
        end else if (m_dead[c] > 0) begin
            if (m_dead[c] == 1) begin
                m_dir[c]  = t_dir[c];
                m_dead[c] = 0;
            end else begin
                m_dead[c] = m_dead[c] - 1;
            end
        end else if (t_dir[c] == m_dir[c]) begin
            delta = t_mag[c] - m_duty[c];
            if (delta > step_of[c])  delta = step_of[c];
            if (delta < -step_of[c]) delta = -step_of[c];
            m_duty[c] = m_duty[c] + delta;
        end else begin
            m_duty[c] = (m_duty[c] > step_of[c]) ? m_duty[c] - step_of[c] : 0;
            if (m_duty[c] == 0) m_dead[c] = dead_of[c];
        end
    endtask

    // Effect of one clock edge on channel c, given that cycle's inputs
    task automatic model_edge(input int c, input logic e, input logic v, input logic [11:0] ci);
        int val;
        if (!e) begin
            m_run[c]  = 1'b0;
            m_duty[c] = 0;
            m_dead[c] = 0;
        end else if (m_cnt == 2047) begin
            model_period(c);
        end
        if (v) begin
            val = int'($signed(ci));
            t_dir[c] = (val >= 0);
            t_mag[c] = (val < 0) ? -val : val;
            if (t_mag[c] > 2047) t_mag[c] = 2047;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_duty"},  32'(duty),      32'(m_duty[0]));
        chk({tag, "_dir"},   32'(dir),       32'(m_dir[0]));
        chk({tag, "_drv"},   32'(drive_en),  32'(m_run[0] && m_dead[0] == 0));
        chk({tag, "_duty2"}, 32'(duty2),     32'(m_duty[1]));
        chk({tag, "_dir2"},  32'(dir2),      32'(m_dir[1]));
        chk({tag, "_drv2"},  32'(drive_en2), 32'(m_run[1] && m_dead[1] == 0));
    endtask

    // Driver: advance one clock, compare at period boundaries, refresh random inputs
    task automatic step();
        model_edge(0, en, cmd_vld, cmd);
        model_edge(1, en2, cmd_vld2, cmd2);
        m_cnt = (m_cnt + 1) % 2048;
        @(posedge clk);
        #1;
        if (m_cnt == 0) check_all("pend");
        if (m_cnt >= 2046 || m_cnt == 0) begin
            chk("period_end",  32'(period_end),  32'(m_cnt == 2047));
            chk("period_end2", 32'(period_end2), 32'(m_cnt == 2047));
        end
        if (rnd_on) begin
            cmd_vld2 = 1'b0;
            if ($urandom_range(0, 399) == 0 || (m_cnt == 2047 && $urandom_range(0, 1) == 1)) begin
                cmd_vld2 = 1'b1;
                case ($urandom_range(0, 4))
                    0:       cmd2 = 12'h800;
                    1:       cmd2 = 12'h7FF;
                    2:       cmd2 = 12'h000;
                    default: cmd2 = 12'($urandom_range(0, 4095));
                endcase
            end
            en2 = ($urandom_range(0, 2999) != 0);
        end
    endtask

    task automatic pulse_cmd(input logic [11:0] value);
        cmd     = value;
        cmd_vld = 1'b1;
        step();
        cmd_vld = 1'b0;
    endtask

    task automatic run_to_pend();
        do step(); while (m_cnt != 0);
    endtask

    task automatic wait_cnt(input int value);
        while (m_cnt != value) step();
    endtask

    int exp_t1[7]  = '{16, 32, 48, 64, 80, 96, 100};
    int exp_t2d[8] = '{48, 32, 16, 0, 0, 0, 16, 32};
    int exp_t2e[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    int exp_t2r[8] = '{1, 1, 1, 1, 1, 0, 0, 0};

    initial begin
        int n;
        rst_n    = 1'b0;
        en       = 1'b0;
        cmd      = 12'd0;
        cmd_vld  = 1'b0;
        en2      = 1'b0;
        cmd2     = 12'd0;
        cmd_vld2 = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_duty",  32'(duty),        32'd0);
        chk("rst_dir",   32'(dir),         32'd1);
        chk("rst_drv",   32'(drive_en),    32'd0);
        chk("rst_pe",    32'(period_end),  32'd0);
        chk("rst_duty2", 32'(duty2),       32'd0);
        chk("rst_drv2",  32'(drive_en2),   32'd0);
        rst_n = 1'b1;

        // Forward ramp to +100 on ch0; ch1 ramps to +2047 in large steps
        en       = 1'b1;
        en2      = 1'b1;
        cmd2     = 12'h7FF;
        cmd_vld2 = 1'b1;
        pulse_cmd(12'd100);
        cmd_vld2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            run_to_pend();
            chk("t1_duty", 32'(duty),     32'(exp_t1[k]));
            chk("t1_dir",  32'(dir),      32'd1);
            chk("t1_drv",  32'(drive_en), 32'd1);
            if (k == 1) chk("t3_duty2_mid", 32'(duty2), 32'd1400);
            if (k == 2) chk("t3_duty2_top", 32'(duty2), 32'd2047);
        end

        // Down to +64, then reverse to -32; ch1 reverses from full scale with -2048
        cmd2     = 12'h800;
        cmd_vld2 = 1'b1;
        pulse_cmd(12'd64);
        cmd_vld2 = 1'b0;
        run_to_pend();
        chk("t2_duty84", 32'(duty), 32'd84);
        chk("t3_duty2_dn", 32'(duty2), 32'd1347);
        run_to_pend();
        chk("t2_duty68", 32'(duty), 32'd68);
        run_to_pend();
        chk("t2_duty64", 32'(duty), 32'd64);
        chk("t3_duty2_zero", 32'(duty2),     32'd0);
        chk("t3_drv2_off",   32'(drive_en2), 32'd0);
        pulse_cmd(12'hFE0);
        for (int k = 0; k < 8; k++) begin
            run_to_pend();
            chk("t2_duty", 32'(duty),     32'(exp_t2d[k]));
            chk("t2_drv",  32'(drive_en), 32'(exp_t2e[k]));
            chk("t2_dir",  32'(dir),      32'(exp_t2r[k]));
            if (k == 0) begin
                chk("t3_dir2_rev", 32'(dir2),      32'd0);
                chk("t3_drv2_on",  32'(drive_en2), 32'd1);
            end
        end

        // Enable drop mid-ramp, then restart from zero
        rnd_on = 1'b1;
        pulse_cmd(12'hF9C);
        run_to_pend();
        chk("t4_duty48", 32'(duty), 32'd48);
        wait_cnt(500);
        en = 1'b0;
        step();
        chk("t4_off_duty", 32'(duty),     32'd0);
        chk("t4_off_drv",  32'(drive_en), 32'd0);
        chk("t4_off_dir",  32'(dir),      32'd0);
        repeat (10) step();
        en = 1'b1;
        run_to_pend();
        chk("t4_restart", 32'(duty), 32'd16);
        chk("t4_rdrv",    32'(drive_en), 32'd1);

        // Strobe coincident with period end: old target governs that boundary
        pulse_cmd(12'hFA6);
        repeat (5) run_to_pend();
        chk("t5_duty90", 32'(duty), 32'd90);
        pulse_cmd(12'hF9C);
        wait_cnt(2047);
        pulse_cmd(12'hFEC);
        chk("t5_old_tgt", 32'(duty), 32'd100);
        run_to_pend();
        chk("t5_new_tgt", 32'(duty), 32'd84);

        // Settle into HOLD, then asynchronous reset mid-period
        pulse_cmd(12'hFAC);
        run_to_pend();
        chk("t6_hold", 32'(duty), 32'd84);
        wait_cnt(1234);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_duty",  32'(duty),        32'd0);
        chk("t6_dir",   32'(dir),         32'd1);
        chk("t6_drv",   32'(drive_en),    32'd0);
        chk("t6_pe",    32'(period_end),  32'd0);
        chk("t6_duty2", 32'(duty2),       32'd0);
        chk("t6_drv2",  32'(drive_en2),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (period_end !== 1'b1 && n < 3000);
        chk("t6_pe_delay", 32'(n), 32'd2047);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
